// File: rtl/md_unit_e.sv
// md_unit_e: execute-stage multiply/divide unit with HI/LO registers.
// Runs mult/multu/div/divu over a fixed busy period and services mfhi/mflo/mthi/mtlo.
`default_nettype none

module md_unit_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_OUT
);

  localparam logic [5:0] c_fn_mfhi  = 6'b010000;
  localparam logic [5:0] c_fn_mthi  = 6'b010001;
  localparam logic [5:0] c_fn_mflo  = 6'b010010;
  localparam logic [5:0] c_fn_mtlo  = 6'b010011;
  localparam logic [5:0] c_fn_mult  = 6'b011000;
  localparam logic [5:0] c_fn_multu = 6'b011001;
  localparam logic [5:0] c_fn_div   = 6'b011010;
  localparam logic [5:0] c_fn_divu  = 6'b011011;

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_special;
  logic        is_mult, is_multu, is_div, is_divu;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        div_ovf;
  logic        unused_ir;

  assign unused_ir = ^IR_E[25:6];

  always_comb begin
    is_special = (IR_E[31:26] == 6'b000000);
    is_mult    = is_special && (IR_E[5:0] == c_fn_mult);
    is_multu   = is_special && (IR_E[5:0] == c_fn_multu);
    is_div     = is_special && (IR_E[5:0] == c_fn_div);
    is_divu    = is_special && (IR_E[5:0] == c_fn_divu);
    is_mfhi    = is_special && (IR_E[5:0] == c_fn_mfhi);
    is_mflo    = is_special && (IR_E[5:0] == c_fn_mflo);
    is_mthi    = is_special && (IR_E[5:0] == c_fn_mthi);
    is_mtlo    = is_special && (IR_E[5:0] == c_fn_mtlo);

    start  = (is_mult || is_multu || is_div || is_divu) && !busy_q;
    MD_OUT = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'h0);
  end

  // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
  always_comb begin
    prod_s  = {{32{RS_E[31]}}, RS_E} * {{32{RT_E[31]}}, RT_E};
    prod_u  = {32'h0, RS_E} * {32'h0, RT_E};
    divisor = (RT_E == 32'h0) ? 32'h1 : RT_E;
    div_ovf = (RS_E == 32'h8000_0000) && (RT_E == 32'hFFFF_FFFF);
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'h0;
    end else begin
      quo_s = $signed(RS_E) / $signed(divisor);
      rem_s = $signed(RS_E) % $signed(divisor);
    end
    quo_u = RS_E / divisor;
    rem_u = RS_E % divisor;
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          if (is_mult) begin
            cnt_d  = c_mult_cnt;
            p_hi_d = prod_s[63:32];
            p_lo_d = prod_s[31:0];
          end else if (is_multu) begin
            cnt_d  = c_mult_cnt;
            p_hi_d = prod_u[63:32];
            p_lo_d = prod_u[31:0];
          end else begin
            cnt_d = c_div_cnt;
            // Divide by zero commits the current HI/LO, leaving them unchanged.
            if (RT_E == 32'h0) begin
              p_hi_d = hi_q;
              p_lo_d = lo_q;
            end else if (is_div) begin
              p_hi_d = rem_s;
              p_lo_d = quo_s;
            end else begin
              p_hi_d = rem_u;
              p_lo_d = quo_u;
            end
          end
        end else begin
          if (is_mthi) hi_d = RS_E;
          if (is_mtlo) lo_d = RS_E;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'h0;
      p_lo_q  <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: directed self-checking bench for md_unit_e.
`default_nettype none

module tb_md_unit_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_E, RS_E, RT_E;
  logic        start, busy;
  logic [31:0] HI, LO, MD_OUT;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] c_mult  = 32'h0000_0018;
  localparam logic [31:0] c_multu = 32'h0000_0019;
  localparam logic [31:0] c_div   = 32'h0000_001A;
  localparam logic [31:0] c_divu  = 32'h0000_001B;
  localparam logic [31:0] c_mfhi  = 32'h0000_0010;
  localparam logic [31:0] c_mthi  = 32'h0000_0011;
  localparam logic [31:0] c_mflo  = 32'h0000_0012;
  localparam logic [31:0] c_mtlo  = 32'h0000_0013;
  localparam logic [31:0] c_add   = 32'h0000_0020;

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .IR_E(IR_E), .RS_E(RS_E), .RT_E(RT_E),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .MD_OUT(MD_OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count busy cycles (bounded) until it completes.
  task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] rs,
                       input logic [31:0] rt, input int exp_cycles);
    int n;
    IR_E = ir; RS_E = rs; RT_E = rt;
    #1;
    check({tag, "_start"}, {31'h0, start}, 32'h1);
    tick();
    IR_E = 32'h0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
  endtask

  initial begin
    int start_seen;
    reset = 1'b1; IR_E = 32'h0; RS_E = 32'h0; RT_E = 32'h0;
    tick(); tick();
    check("rst_busy",  {31'h0, busy},  32'h0);
    check("rst_hi",    HI, 32'h0);
    check("rst_lo",    LO, 32'h0);
    check("rst_start", {31'h0, start}, 32'h0);
    check("rst_mdout", MD_OUT, 32'h0);
    reset = 1'b0;
    tick();

    issue("mult", c_mult, 32'hFFFF_FFFE, 32'h3, 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    IR_E = c_mflo; #1;
    check("mflo_mult", MD_OUT, 32'hFFFF_FFFA);
    IR_E = c_add; #1;
    check("mdout_other", MD_OUT, 32'h0);

    issue("multu", c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue("div", c_div, 32'hFFFF_FFF9, 32'h2, 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue("divu", c_divu, 32'hFFFF_FFF9, 32'h2, 10);
    check("divu_lo", LO, 32'h7FFF_FFFC);
    check("divu_hi", HI, 32'h0000_0001);

    issue("div_ovf", c_div, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    // mthi: 1-cycle write latency, no busy period
    IR_E = c_mthi; RS_E = 32'h1234_5678; #1;
    check("mthi_start", {31'h0, start}, 32'h0);
    tick();
    check("mthi_busy", {31'h0, busy}, 32'h0);
    IR_E = c_mfhi; #1;
    check("mthi_mfhi", MD_OUT, 32'h1234_5678);

    issue("div0", c_div, 32'h0000_0064, 32'h0, 10);
    check("div0_hi", HI, 32'h1234_5678);
    check("div0_lo", LO, 32'h8000_0000);
    IR_E = c_mfhi; #1;
    check("div0_mfhi", MD_OUT, 32'h1234_5678);

    // div in flight with mult then mtlo held on IR_E: both ignored
    IR_E = c_div; RS_E = 32'd100; RT_E = 32'd7; #1;
    check("hold_start", {31'h0, start}, 32'h1);
    tick();
    start_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        IR_E = c_mult; RS_E = 32'd9; RT_E = 32'd9;
      end else begin
        IR_E = c_mtlo; RS_E = 32'hDEAD_BEEF;
      end
      #1;
      if (start) start_seen++;
      tick();
    end
    IR_E = 32'h0;
    check("hold_no_start", start_seen, 32'd0);
    check("hold_busy_done", {31'h0, busy}, 32'h0);
    check("hold_lo", LO, 32'd14);
    check("hold_hi", HI, 32'd2);
    tick();
    check("hold_lo_after", LO, 32'd14);

    // reset on busy cycle 3 of a mult
    IR_E = c_mult; RS_E = 32'd6; RT_E = 32'd7; #1;
    tick();
    IR_E = 32'h0;
    tick();
    tick();
    check("rstmid_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    check("rstmid_busy", {31'h0, busy}, 32'h0);
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rstmid_hi_later", HI, 32'h0);
    check("rstmid_lo_later", LO, 32'h0);
    check("rstmid_busy_later", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
